// File: rtl/cdb_arbiter_if.sv
// Result-broadcast bus bundle: producer channels on one side, the common data bus on the other.
// The producer (master) drives in_valid/in_tag/in_data; the arbiter (slave) drives in_ready and cdb_*.
interface cdb_arbiter_if #(
    parameter int NCH    = 2,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    localparam int SW = $clog2(NCH);

    logic [NCH-1:0]        in_valid;
    logic [NCH*TAG_W-1:0]  in_tag;
    logic [NCH*DATA_W-1:0] in_data;
    logic [NCH-1:0]        in_ready;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [DATA_W-1:0]     cdb_data;
    logic [SW-1:0]         cdb_src;

    modport master (
        output in_valid, in_tag, in_data,
        input  in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  in_valid, in_tag, in_data,
        output in_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-channel result FIFOs feeding a round-robin arbiter that broadcasts one result per cycle on the CDB.
// Define CDB_BYPASS_EN to let an empty channel's incoming result go straight to the CDB registers.
module cdb_arbiter #(
    parameter int NCH    = 2,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    cdb_arbiter_if.slave bus
);
    localparam int SW = $clog2(NCH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [SW-1:0] LAST_CH  = SW'(NCH - 1);

    logic [TAG_W-1:0]  tag_mem_r  [NCH][DEPTH];
    logic [DATA_W-1:0] data_mem_r [NCH][DEPTH];
    logic [PW-1:0]     wr_ptr_r   [NCH];
    logic [PW-1:0]     rd_ptr_r   [NCH];
    logic [PW:0]       cnt_r      [NCH];
    logic [SW-1:0]     rr_ptr_r;
    logic              cdb_valid_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [DATA_W-1:0] cdb_data_r;
    logic [SW-1:0]     cdb_src_r;

    logic [TAG_W-1:0]  in_tag_s  [NCH];
    logic [DATA_W-1:0] in_data_s [NCH];
    logic [NCH-1:0]    ready_s;
    logic [NCH-1:0]    acc_s;
    logic [NCH-1:0]    eligible_s;
    logic [NCH-1:0]    wr_s;
    logic [NCH-1:0]    pop_s;
    logic              gnt_found_s;
    logic [SW-1:0]     gnt_idx_s;
    logic [SW-1:0]     rr_next_s;
    logic [TAG_W-1:0]  gnt_tag_s;
    logic [DATA_W-1:0] gnt_data_s;

    // Per-channel unpacking, readiness, accepted pushes and arbitration eligibility
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            in_tag_s[i]  = bus.in_tag[i*TAG_W +: TAG_W];
            in_data_s[i] = bus.in_data[i*DATA_W +: DATA_W];
            ready_s[i]   = rst && (cnt_r[i] < FULL_CNT);
            acc_s[i]     = bus.in_valid[i] && ready_s[i] && !flush;
`ifdef CDB_BYPASS_EN
            eligible_s[i] = (cnt_r[i] != '0) || acc_s[i];
`else
            eligible_s[i] = (cnt_r[i] != '0);
`endif
        end
    end

    // Round-robin search starting at rr_ptr_r, wrapping to channel 0
    always_comb begin
        logic hit_s;
        gnt_found_s = 1'b0;
        gnt_idx_s   = rr_ptr_r;
        for (int k = 0; k < NCH; k++) begin
            hit_s       = !gnt_found_s && eligible_s[(int'(rr_ptr_r) + k) % NCH];
            gnt_found_s = gnt_found_s || hit_s;
            gnt_idx_s   = hit_s ? SW'((int'(rr_ptr_r) + k) % NCH) : gnt_idx_s;
        end
    end

    // Granted payload, next pointer, and per-channel pop/write strobes
    always_comb begin
        rr_next_s  = (gnt_idx_s == LAST_CH) ? '0 : gnt_idx_s + SW'(1);
`ifdef CDB_BYPASS_EN
        // An empty granted channel can only have won through its live input
        gnt_tag_s  = (cnt_r[gnt_idx_s] == '0) ? in_tag_s[gnt_idx_s]
                                              : tag_mem_r[gnt_idx_s][rd_ptr_r[gnt_idx_s]];
        gnt_data_s = (cnt_r[gnt_idx_s] == '0) ? in_data_s[gnt_idx_s]
                                              : data_mem_r[gnt_idx_s][rd_ptr_r[gnt_idx_s]];
`else
        gnt_tag_s  = tag_mem_r[gnt_idx_s][rd_ptr_r[gnt_idx_s]];
        gnt_data_s = data_mem_r[gnt_idx_s][rd_ptr_r[gnt_idx_s]];
`endif
        for (int i = 0; i < NCH; i++) begin
            pop_s[i] = gnt_found_s && (gnt_idx_s == SW'(i)) && (cnt_r[i] != '0);
            wr_s[i]  = acc_s[i] && !(gnt_found_s && (gnt_idx_s == SW'(i)) && (cnt_r[i] == '0));
        end
    end

    // Buffer storage, written on accepted pushes that are not bypassed
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (wr_s[i]) begin
                tag_mem_r[i][wr_ptr_r[i]]  <= in_tag_s[i];
                data_mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
            end
        end
    end

    // FIFO bookkeeping, round-robin pointer and CDB output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
            rr_ptr_r    <= '0;
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= '0;
            cdb_data_r  <= '0;
            cdb_src_r   <= '0;
        end else if (flush) begin
            // Mispredict recovery drops everything buffered; last broadcast payload is kept
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
            rr_ptr_r    <= '0;
            cdb_valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
                end
                case ({wr_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + (PW+1)'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - (PW+1)'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
            if (gnt_found_s) begin
                cdb_valid_r <= 1'b1;
                cdb_tag_r   <= gnt_tag_s;
                cdb_data_r  <= gnt_data_s;
                cdb_src_r   <= gnt_idx_s;
                rr_ptr_r    <= rr_next_s;
            end else begin
                cdb_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.cdb_valid = cdb_valid_r;
    assign bus.cdb_tag   = cdb_tag_r;
    assign bus.cdb_data  = cdb_data_r;
    assign bus.cdb_src   = cdb_src_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NCH=2, DEPTH=2), default build without the bypass path.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_cdb_arbiter;
    logic clk;
    logic rst;
    logic flush;
    int   errors;
    int   checks;

    cdb_arbiter_if #(.NCH(2), .TAG_W(4), .DATA_W(32)) bus ();

    cdb_arbiter #(.NCH(2), .DEPTH(2), .TAG_W(4), .DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input int ch, input logic [3:0] t);
        return ((ch == 0) ? 32'hC0DE_0000 : 32'hC1DE_0000) | {28'h0, t};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1);
        bus.in_valid = v;
        bus.in_tag   = {t1, t0};
        bus.in_data  = {dat(1, t1), dat(0, t0)};
    endtask

    task automatic expect_bc(input string tag, input logic [3:0] t, input logic src, input int ch);
        check_eq({tag, "_valid"}, {63'h0, bus.cdb_valid}, 64'h1);
        check_eq({tag, "_tag"},   {60'h0, bus.cdb_tag},   {60'h0, t});
        check_eq({tag, "_src"},   {63'h0, bus.cdb_src},   {63'h0, src});
        check_eq({tag, "_data"},  {32'h0, bus.cdb_data},  {32'h0, dat(ch, t)});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        flush  = 1'b0;
        drive(2'b00, 4'h0, 4'h0);

        // Reset state
        step();
        step();
        check_eq("rst_valid", {63'h0, bus.cdb_valid}, 64'h0);
        check_eq("rst_tag",   {60'h0, bus.cdb_tag},   64'h0);
        check_eq("rst_data",  {32'h0, bus.cdb_data},  64'h0);
        check_eq("rst_src",   {63'h0, bus.cdb_src},   64'h0);
        check_eq("rst_ready", {62'h0, bus.in_ready},  64'h0);
        rst = 1'b1;
        #1;
        check_eq("ready_after_rst", {62'h0, bus.in_ready}, 64'h3);

        // Single result through the buffer: accepted at edge 1, broadcast at edge 2
        drive(2'b01, 4'd3, 4'd0);
        bus.in_data[31:0] = 32'hDEAD_BEEF;
        step();
        drive(2'b00, 4'd0, 4'd0);
        check_eq("single_e1_valid", {63'h0, bus.cdb_valid}, 64'h0);
        step();
        check_eq("single_valid", {63'h0, bus.cdb_valid}, 64'h1);
        check_eq("single_tag",   {60'h0, bus.cdb_tag},   64'h3);
        check_eq("single_data",  {32'h0, bus.cdb_data},  64'hDEAD_BEEF);
        check_eq("single_src",   {63'h0, bus.cdb_src},   64'h0);
        step();
        check_eq("single_e3_valid", {63'h0, bus.cdb_valid}, 64'h0);
        check_eq("single_e3_hold",  {60'h0, bus.cdb_tag},   64'h3);

        // Flush: rr_ptr is 1 here, so ch1 wins first
        drive(2'b11, 4'd4, 4'd12);
        step();
        check_eq("fl_e1_valid", {63'h0, bus.cdb_valid}, 64'h0);
        drive(2'b11, 4'd5, 4'd13);
        step();
        expect_bc("fl_e2", 4'd12, 1'b1, 1);
        flush = 1'b1;
        drive(2'b11, 4'd6, 4'd14);
        step();
        flush = 1'b0;
        drive(2'b00, 4'd0, 4'd0);
        #1;
        check_eq("fl_valid", {63'h0, bus.cdb_valid}, 64'h0);
        check_eq("fl_ready", {62'h0, bus.in_ready},  64'h3);
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("fl_stale", {63'h0, bus.cdb_valid}, 64'h0);
        end

        // Round-robin from rr_ptr=0, with ch1 filling up and one blocked push
        drive(2'b11, 4'd1, 4'd9);
        step();
        check_eq("rr_e1_valid", {63'h0, bus.cdb_valid}, 64'h0);
        drive(2'b11, 4'd2, 4'd10);
        step();
        expect_bc("rr0", 4'd1, 1'b0, 0);
        check_eq("full_ready", {62'h0, bus.in_ready}, 64'h1);
        drive(2'b11, 4'd3, 4'd11);
        step();
        expect_bc("rr1", 4'd9, 1'b1, 1);
        drive(2'b10, 4'd0, 4'd11);
        step();
        expect_bc("rr2", 4'd2, 1'b0, 0);
        drive(2'b00, 4'd0, 4'd0);
        step();
        expect_bc("rr3", 4'd10, 1'b1, 1);
        step();
        expect_bc("rr4", 4'd3, 1'b0, 0);
        step();
        expect_bc("rr5", 4'd11, 1'b1, 1);
        step();
        check_eq("rr_idle", {63'h0, bus.cdb_valid}, 64'h0);

        // Same-cycle push and pop on ch0
        drive(2'b01, 4'd6, 4'd0);
        step();
        check_eq("pp_e1_valid", {63'h0, bus.cdb_valid}, 64'h0);
        drive(2'b01, 4'd7, 4'd0);
        step();
        expect_bc("pp_head", 4'd6, 1'b0, 0);
        check_eq("pp_ready", {62'h0, bus.in_ready}, 64'h3);
        drive(2'b00, 4'd0, 4'd0);
        step();
        expect_bc("pp_next", 4'd7, 1'b0, 0);
        step();
        check_eq("pp_idle", {63'h0, bus.cdb_valid}, 64'h0);

        // Reset mid-stream while ch0 holds tags 5 and 6
        drive(2'b11, 4'd5, 4'd15);
        step();
        check_eq("rm_e1_valid", {63'h0, bus.cdb_valid}, 64'h0);
        drive(2'b01, 4'd6, 4'd0);
        step();
        expect_bc("rm_ch1", 4'd15, 1'b1, 1);
        rst = 1'b0;
        drive(2'b00, 4'd0, 4'd0);
        step();
        check_eq("rm_valid", {63'h0, bus.cdb_valid}, 64'h0);
        check_eq("rm_tag",   {60'h0, bus.cdb_tag},   64'h0);
        check_eq("rm_data",  {32'h0, bus.cdb_data},  64'h0);
        check_eq("rm_src",   {63'h0, bus.cdb_src},   64'h0);
        check_eq("rm_ready", {62'h0, bus.in_ready},  64'h0);
        rst = 1'b1;
        #1;
        check_eq("rm_ready_back", {62'h0, bus.in_ready}, 64'h3);
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("rm_no_stale", {63'h0, bus.cdb_valid}, 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NCH, default 2: number of producer channels (ALU, LSU, ...), range 2..8.
REQ-002 Parameter DEPTH, default 2: per-channel buffer entries, power of two, range 2..16.
REQ-003 Parameter TAG_W, default 4: ROB tag width.
REQ-004 Parameter DATA_W, default 32: result data width.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 flush  input  1  synchronous clear of all buffered results (mispredict recovery).
REQ-008 in_valid  input  NCH  per-channel result valid.
REQ-009 in_tag  input  NCH*TAG_W  per-channel ROB tag, channel i at bits [i*TAG_W +: TAG_W].
REQ-010 in_data  input  NCH*DATA_W  per-channel result, channel i at bits [i*DATA_W +: DATA_W].
REQ-011 in_ready  output  NCH  per-channel buffer can accept.
REQ-012 cdb_valid  output  1  broadcast valid, one-cycle pulse per result.
REQ-013 cdb_tag  output  TAG_W  broadcast ROB tag.
REQ-014 cdb_data  output  DATA_W  broadcast result.
REQ-015 cdb_src  output  clog2(NCH)  index of the channel that produced the broadcast.

Function
REQ-016 Channel i transfer occurs on a rising edge where in_valid[i] and in_ready[i] are both 1, rst is 1 and flush is 0.
REQ-017 in_ready[i] is 1 when channel i holds fewer than DEPTH entries, is 0 while rst is 0, and does not depend on in_valid.
REQ-018 Each channel buffer is FIFO; read/write pointers wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits wide.
REQ-019 Each cycle, an arbiter selects one channel with a non-empty buffer, searching round-robin from rr_ptr upward with wrap to 0.
REQ-020 On a grant to channel g, the head entry pops, and cdb_valid=1, cdb_tag, cdb_data and cdb_src=g are registered at that edge; rr_ptr becomes (g+1) mod NCH.
REQ-021 If no channel is eligible, cdb_valid is registered 0, rr_ptr is held, and cdb_tag, cdb_data and cdb_src hold their previous values.
REQ-022 Push and pop on the same channel in the same cycle leave the occupancy unchanged; the pushed entry queues behind the remaining entries.
REQ-023 Latency with the buffer path: a result accepted at edge N is broadcast at edge N+1 at the earliest, with cdb_valid high after edge N+1.
REQ-024 The CDB has no backpressure; every granted result is broadcast exactly once, and results from one channel are broadcast in acceptance order.
REQ-025 Starvation bound: a non-empty channel is granted within NCH cycles.
REQ-026 While flush is 1, at the edge all buffers empty, no push occurs, cdb_valid is registered 0, and rr_ptr is set to 0.
REQ-027 flush and rst have priority over all pushes and grants in the same cycle.

Reset
REQ-028 When rst is 0 at a rising edge, all occupancies, pointers and rr_ptr are set to 0, and cdb_valid, cdb_tag, cdb_data and cdb_src are set to 0.
REQ-029 Reset asserted mid-operation discards all buffered results, and no broadcast occurs at the next edge.
REQ-030 In the first cycle after rst returns to 1, in_ready is all-ones.

Configuration
REQ-031 Macro CDB_BYPASS_EN compiles the bypass path in.
REQ-032 With CDB_BYPASS_EN defined: if channel i's buffer is empty, in_valid[i] is 1 and i wins arbitration among empty-buffer bypass candidates and non-empty buffers, then the input goes directly to the cdb_* registers at the accepting edge (latency 1 edge) and is not written to the buffer.
REQ-033 Without CDB_BYPASS_EN: no bypass path exists; every result passes through its buffer, and REQ-023 latency applies.

Verification
REQ-034 Single result: ch0 pushes tag=3, data=0xDEADBEEF at edge 1 -> cdb_valid=1, tag=3, data=0xDEADBEEF, src=0 after edge 2 (after edge 1 with CDB_BYPASS_EN); cdb_valid=0 after edge 3.
REQ-035 Round-robin: NCH=2, both channels hold 3 entries each, rr_ptr=0 -> cdb_src sequence 0,1,0,1,0,1 on consecutive cycles, then cdb_valid=0.
REQ-036 Full: DEPTH=2, ch1 pushes 2 entries while ch0 is continuously granted -> in_ready[1]=0 after the second push; a third push is blocked and no data is lost.
REQ-037 Flush: 2 entries buffered in each channel, flush=1 for one cycle -> cdb_valid=0 next cycle, in_ready all-ones, no stale tag broadcast thereafter.
REQ-038 Reset mid-stream: rst=0 while ch0 holds tags 5 and 6 -> all outputs 0 after the edge, and tags 5 and 6 never appear on the CDB.
REQ-039 Same-cycle push/pop: ch0 holds 1 entry, pushes tag=7 while its head is granted -> occupancy stays 1, and tag 7 is broadcast next.
